// File: rtl/io_bus_arbiter_pkg.sv
// Shared types and address map for the peripheral I/O bus.
// Provides the peripheral enum and the address decoder.
package io_bus_arbiter_pkg;

    typedef logic [31:0] scalar_t;

    typedef enum logic [2:0] {
        UART,
        SDCARD,
        PS2,
        VGA,
        TIMER,
        LCD,
        NONE
    } io_periph_t;

    localparam scalar_t UART_BASE    = 32'h0000_0040;
    localparam scalar_t UART_LIMIT   = 32'h0000_007f;
    localparam scalar_t PS2_BASE     = 32'h0000_0080;
    localparam scalar_t PS2_LIMIT    = 32'h0000_00bf;
    localparam scalar_t SDCARD_BASE  = 32'h0000_00c0;
    localparam scalar_t SDCARD_LIMIT = 32'h0000_00ff;
    localparam scalar_t VGA_BASE     = 32'h0000_0180;
    localparam scalar_t VGA_LIMIT    = 32'h0000_01bf;
    localparam scalar_t TIMER_BASE   = 32'h0000_0240;
    localparam scalar_t TIMER_LIMIT  = 32'h0000_0243;
    localparam scalar_t LCD_BASE     = 32'h0000_0244;
    localparam scalar_t LCD_LIMIT    = 32'h0000_027f;

    function automatic io_periph_t io_decode(input scalar_t addr);
        io_periph_t p;
        p = NONE;
        if (addr >= UART_BASE && addr <= UART_LIMIT)
            p = UART;
        else if (addr >= PS2_BASE && addr <= PS2_LIMIT)
            p = PS2;
        else if (addr >= SDCARD_BASE && addr <= SDCARD_LIMIT)
            p = SDCARD;
        else if (addr >= VGA_BASE && addr <= VGA_LIMIT)
            p = VGA;
        else if (addr >= TIMER_BASE && addr <= TIMER_LIMIT)
            p = TIMER;
        else if (addr >= LCD_BASE && addr <= LCD_LIMIT)
            p = LCD;
        return p;
    endfunction

endpackage

// File: rtl/io_bus_arbiter_rr_arbiter.sv
// Round-robin arbiter with one-hot grant.
// Search starts just past the most recently granted requester.
module rr_arbiter #(
    parameter int NUM_REQUESTERS = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic                      update_lru,
    output logic [NUM_REQUESTERS-1:0] grant_oh
);

    localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] next_idx;
    logic             found;
    int               cand;

    always_comb begin
        grant_oh = '0;
        next_idx = last_grant;
        found    = 1'b0;
        cand     = 0;
        for (int i = 1; i <= NUM_REQUESTERS; i++) begin
            cand = (int'(last_grant) + i) % NUM_REQUESTERS;
            if (!found && request[cand]) begin
                found          = 1'b1;
                grant_oh[cand] = 1'b1;
                next_idx       = IDX_W'(cand);
            end
        end
    end

    // Reset to the last index so requester 0 has first priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last_grant <= IDX_W'(NUM_REQUESTERS - 1);
        else if (update_lru)
            last_grant <= next_idx;
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares the peripheral I/O bus between the core and a debug/DMA master.
// One transfer per cycle; response returns exactly one cycle later.
module io_bus_arbiter
    import io_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS  = 2,
    parameter int NUM_PERIPHERALS = 6
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_REQUESTERS-1:0]        req_valid,
    output logic [NUM_REQUESTERS-1:0]        req_ready,
    input  logic [NUM_REQUESTERS-1:0]        req_write,
    input  logic [NUM_REQUESTERS-1:0][31:0]  req_address,
    input  logic [NUM_REQUESTERS-1:0][31:0]  req_wdata,
    output logic [NUM_REQUESTERS-1:0]        resp_valid,
    output logic [31:0]                      resp_rdata,
    output logic                             io_write_en,
    output logic                             io_read_en,
    output logic [31:0]                      io_address,
    output logic [31:0]                      io_write_data,
    input  logic [NUM_PERIPHERALS-1:0][31:0] periph_read_data,
    output logic                             decode_error
);

    localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

    typedef struct packed {
        logic             valid;
        logic             write;
        logic [IDX_W-1:0] req_idx;
        io_periph_t       periph;
    } resp_t;

    logic [NUM_REQUESTERS-1:0] request;
    logic [NUM_REQUESTERS-1:0] grant_oh;
    logic                      grant_any;
    logic [IDX_W-1:0]          grant_idx;
    io_periph_t                periph;
    resp_t                     resp_q;

    // No grants while reset is held.
    assign request   = req_valid & {NUM_REQUESTERS{reset_n}};
    assign grant_any = |grant_oh;
    assign req_ready = grant_oh;

    rr_arbiter #(
        .NUM_REQUESTERS(NUM_REQUESTERS)
    ) u_rr_arbiter (
        .clk       (clk),
        .reset_n   (reset_n),
        .request   (request),
        .update_lru(grant_any),
        .grant_oh  (grant_oh)
    );

    always_comb begin
        grant_idx     = '0;
        io_write_en   = 1'b0;
        io_read_en    = 1'b0;
        io_address    = '0;
        io_write_data = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++)
            if (grant_oh[i])
                grant_idx = IDX_W'(i);
        if (grant_any) begin
            io_write_en   = req_write[grant_idx];
            io_read_en    = !req_write[grant_idx];
            io_address    = req_address[grant_idx];
            io_write_data = req_wdata[grant_idx];
        end
    end

    assign periph = io_decode(io_address);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_q       <= '{valid: 1'b0, write: 1'b0,
                              req_idx: '0, periph: NONE};
            decode_error <= 1'b0;
        end else begin
            resp_q.valid   <= grant_any;
            resp_q.write   <= io_write_en;
            resp_q.req_idx <= grant_idx;
            resp_q.periph  <= periph;
            if (grant_any && periph == NONE)
                decode_error <= 1'b1;
        end
    end

    always_comb begin
        resp_valid = '0;
        resp_rdata = '0;
        if (resp_q.valid) begin
            resp_valid[resp_q.req_idx] = 1'b1;
            if (!resp_q.write && resp_q.periph != NONE &&
                int'(resp_q.periph) < NUM_PERIPHERALS)
                resp_rdata = periph_read_data[resp_q.periph];
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter.
// Directed vectors; responses are checked by a separate monitor.
module tb_io_bus_arbiter;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_write;
    logic [1:0][31:0]  req_address;
    logic [1:0][31:0]  req_wdata;
    logic [1:0]        resp_valid;
    logic [31:0]       resp_rdata;
    logic              io_write_en;
    logic              io_read_en;
    logic [31:0]       io_address;
    logic [31:0]       io_write_data;
    logic [5:0][31:0]  periph_read_data;
    logic              decode_error;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [31:0] D_UART   = 32'h0000_00a5;
    localparam logic [31:0] D_SDCARD = 32'h5d5d_0001;
    localparam logic [31:0] D_PS2    = 32'h2222_0002;
    localparam logic [31:0] D_VGA    = 32'h7a7a_0003;
    localparam logic [31:0] D_TIMER  = 32'h7171_0004;
    localparam logic [31:0] D_LCD    = 32'h1cd0_0005;

    always #5 clk = ~clk;

    io_bus_arbiter #(
        .NUM_REQUESTERS (2),
        .NUM_PERIPHERALS(6)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_address     (req_address),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .io_write_en     (io_write_en),
        .io_read_en      (io_read_en),
        .io_address      (io_address),
        .io_write_data   (io_write_data),
        .periph_read_data(periph_read_data),
        .decode_error    (decode_error)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (resp_valid !== 2'b00) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'(resp_valid), 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_valid", 32'(resp_valid), 32'(e.valid));
                check("resp_rdata", resp_rdata, e.rdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 2'b00;
    endtask

    task automatic set_req(input int r, input logic wr,
                           input logic [31:0] a, input logic [31:0] d);
        req_valid[r]   = 1'b1;
        req_write[r]   = wr;
        req_address[r] = a;
        req_wdata[r]   = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        periph_read_data[0] = D_UART;
        periph_read_data[1] = D_SDCARD;
        periph_read_data[2] = D_PS2;
        periph_read_data[3] = D_VGA;
        periph_read_data[4] = D_TIMER;
        periph_read_data[5] = D_LCD;
        req_write   = 2'b00;
        req_address = '0;
        req_wdata   = '0;
        reset_n     = 1'b0;
        req_valid   = 2'b11;
        req_address[0] = 32'h40;
        req_address[1] = 32'h80;

        // Reset state with requests present
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_strobes", {30'h0, io_write_en, io_read_en}, 32'h0);
        check("rst_io_address", io_address, 32'h0);
        check("rst_io_wdata", io_write_data, 32'h0);
        check("rst_decode_error", 32'(decode_error), 32'h0);
        idle();
        step();
        reset_n = 1'b1;

        // Idle bus
        @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'h0);
        check("idle_strobes", {30'h0, io_write_en, io_read_en}, 32'h0);

        // Core read of UART
        step();
        set_req(0, 1'b0, 32'h40, 32'h0);
        exp_q.push_back('{2'b01, D_UART});
        @(negedge clk);
        check("uart_ready", 32'(req_ready), 32'h1);
        check("uart_read_en", 32'(io_read_en), 32'h1);
        check("uart_write_en", 32'(io_write_en), 32'h0);
        check("uart_address", io_address, 32'h40);

        // Requester 1 writes the timer
        step();
        idle();
        set_req(1, 1'b1, 32'h240, 32'h1234);
        exp_q.push_back('{2'b10, 32'h0});
        @(negedge clk);
        check("wr_ready", 32'(req_ready), 32'h2);
        check("wr_write_en", 32'(io_write_en), 32'h1);
        check("wr_read_en", 32'(io_read_en), 32'h0);
        check("wr_address", io_address, 32'h240);
        check("wr_wdata", io_write_data, 32'h1234);

        // Both requesters contend for four cycles
        step();
        idle();
        check("wr_decode_error", 32'(decode_error), 32'h0);
        set_req(0, 1'b0, 32'h80, 32'h0);
        set_req(1, 1'b0, 32'h244, 32'h0);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0)
                exp_q.push_back('{2'b01, D_PS2});
            else
                exp_q.push_back('{2'b10, D_LCD});
            @(negedge clk);
            check("rr_ready", 32'(req_ready),
                  (k % 2 == 0) ? 32'h1 : 32'h2);
            check("rr_address", io_address,
                  (k % 2 == 0) ? 32'h80 : 32'h244);
            step();
        end

        // Unmapped read sets the sticky error
        idle();
        set_req(0, 1'b0, 32'h300, 32'h0);
        exp_q.push_back('{2'b01, 32'h0});
        @(negedge clk);
        check("none_ready", 32'(req_ready), 32'h1);
        check("none_read_en", 32'(io_read_en), 32'h1);
        step();
        idle();
        check("none_decode_error", 32'(decode_error), 32'h1);
        set_req(0, 1'b0, 32'hc0, 32'h0);
        exp_q.push_back('{2'b01, D_SDCARD});
        step();
        idle();
        set_req(1, 1'b0, 32'h180, 32'h0);
        exp_q.push_back('{2'b10, D_VGA});
        step();
        idle();
        step();
        check("sticky_decode_error", 32'(decode_error), 32'h1);

        // Reset in the grant cycle drops the response
        set_req(0, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        check("pre_rst_ready", 32'(req_ready), 32'h1);
        #1;
        reset_n = 1'b0;
        idle();
        step();
        step();
        set_req(0, 1'b0, 32'h240, 32'h0);
        set_req(1, 1'b0, 32'h80, 32'h0);
        reset_n = 1'b1;
        exp_q.push_back('{2'b01, D_TIMER});
        @(negedge clk);
        check("post_rst_resp_valid", 32'(resp_valid), 32'h0);
        check("post_rst_ready", 32'(req_ready), 32'h1);
        check("post_rst_decode_error", 32'(decode_error), 32'h0);
        step();
        idle();
        repeat (3) step();
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Shares the single Nyuzi I/O bus between two requesters: the core's `io_bus` port and a debug/DMA master. A fair round-robin arbiter grants one transaction per cycle, drives the broadcast peripheral bus, and decodes the address to a peripheral index. It then returns the selected peripheral's read data to the granted requester one cycle later. It replaces the ad-hoc read-source register in the board top level and sits between the core and the peripheral fan-out.

## Interface
- NUM_REQUESTERS, 2, number of masters; indices are fixed and index 0 is the core.
- NUM_PERIPHERALS, 6, number of peripheral read-data inputs; must match the `io_periph_t` count.
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous and active-low.
- req_valid  in  [NUM_REQUESTERS]  request present.
- req_ready  out  [NUM_REQUESTERS]  request granted this cycle; transfer occurs when valid && ready.
- req_write  in  [NUM_REQUESTERS]  1 = write, 0 = read.
- req_address  in  [NUM_REQUESTERS][32]  byte address.
- req_wdata  in  [NUM_REQUESTERS][32]  write data.
- resp_valid  out  [NUM_REQUESTERS]  response for that requester's transfer of the previous cycle.
- resp_rdata  out  32  read data, shared; qualified by resp_valid.
- io_write_en, io_read_en  out  1 each  broadcast peripheral strobes.
- io_address  out  32  broadcast address.
- io_write_data  out  32  broadcast write data.
- periph_read_data  in  [NUM_PERIPHERALS][32]  per-peripheral read data, valid the cycle after io_read_en.
- decode_error  out  1  sticky flag: a transfer hit an unmapped address.

## Operation
- Arbitration uses round-robin priority. Priority starts at `last_grant + 1` mod NUM_REQUESTERS; the first valid requester from there wins.
- `last_grant` updates only on a granted transfer.
- At most one `req_ready` bit is high per cycle, and it is high only if the matching `req_valid` is high.
- With no valid requests, `req_ready` is all zero and the strobes are low.
- Requesters hold address, data and write stable while valid && !ready. A requester may drop valid only after being granted.
- The grant is combinational, so the winner sees ready in the same cycle. The io_* outputs are combinational copies of the winner's fields: `io_write_en = write`, `io_read_en = !write`.
- Address decode uses the `io_decode()` package function:
  - 0x40–0x7F → UART
  - 0x80–0xBF → PS2
  - 0xC0–0xFF → SDCARD
  - 0x180–0x1BF → VGA
  - 0x240–0x243 → TIMER
  - 0x244–0x27F → LCD
  - anything else → NONE
- Response stage: one register holds `{valid, requester index, periph index}`. It is loaded every cycle: valid = a transfer occurred.
- Next cycle, `resp_valid[idx] = 1` for both reads and writes.
- `resp_rdata = periph_read_data[periph]` for reads. It is 0 for writes and for NONE.
- A transfer to NONE still strobes the bus and responds normally, and it sets `decode_error`. The flag clears only on reset.
- The arbiter is fully pipelined, so back-to-back grants are allowed every cycle.

## Timing
- Reset (asynchronous, while reset_n = 0):
  - `req_ready`, `resp_valid`, `resp_rdata` = 0.
  - io strobes = 0; `io_address`, `io_write_data` = 0.
  - `decode_error` = 0.
  - `last_grant` = NUM_REQUESTERS−1, so requester 0 wins first.
  - The response register is cleared.
- Latency: request accepted in cycle N → response in cycle N+1, always. There is no backpressure on responses.
- Simultaneous requests alternate: 0,1,0,1…
- A single requester holding valid continuously is granted every cycle.
- Reset asserted mid-transfer: a pending response is dropped and no resp_valid appears after deassertion.
- Reset deassertion is synchronized externally; the first grant can occur on the first clock edge after release.

## Structure
- `defines` package:
  - `io_periph_t` enum (UART, SDCARD, PS2, VGA, TIMER, LCD, NONE).
  - Base/limit constants.
  - `io_decode(scalar_t addr)` function.
- Sub-module `rr_arbiter #(NUM_REQUESTERS)`: inputs request/update_lru; outputs a one-hot grant. It reuses the existing core arbiter if its interface matches.
- The top level instantiates one io_bus_arbiter and feeds its io_* outputs to the peripheral_io_bus generate loop.

## Test plan
- Core reads 0x40 with UART read_data = 0xA5 → req_ready[0] same cycle; io_read_en = 1 and io_address = 0x40; next cycle resp_valid = 2'b01 and resp_rdata = 0xA5.
- Both requesters hold reads (0x80, 0x244) for 4 cycles → grants 0,1,0,1; responses carry PS2 then LCD data, each on the cycle after its grant.
- Write 0x1234 to 0x240 → io_write_en = 1 and io_write_data = 0x1234; next cycle resp_valid set with resp_rdata = 0; decode_error stays 0.
- Read 0x300 → resp_rdata = 0 and decode_error = 1; the flag persists through later valid transfers.
- Assert reset_n = 0 in the cycle after a grant → resp_valid stays 0 after release; first grant after release goes to requester 0 when both are valid.
